// File: rtl/syn_fft_butterfly.sv
// Radix-2 DIT butterfly: X = A*2^9 + W*B, Y = A*2^9 - W*B.
// Three-stage pipeline (multiply, combine, add/saturate) with valid/ready
// flow control, a sideband tag and sticky saturation statistics.

package syn_fft_butterfly_pkg;
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } fft_sample_t;

  typedef struct packed {
    logic signed [9:0] re;
    logic signed [9:0] im;
  } fft_twdl_t;

  typedef struct packed {
    logic signed [41:0] re;
    logic signed [41:0] im;
  } butres_t;
endpackage

module syn_fft_butterfly
  import syn_fft_butterfly_pkg::*;
#(
  parameter int P_TAG_W     = 8,
  parameter int P_OVF_CNT_W = 16
) (
  input  logic                   clk_ir,
  input  logic                   rst_ih,
  input  logic                   in_vld_i,
  output logic                   in_rdy_o,
  input  fft_sample_t            sample_a_i,
  input  fft_sample_t            sample_b_i,
  input  fft_twdl_t              twdl_i,
  input  logic [P_TAG_W-1:0]     tag_i,
  output logic                   out_vld_o,
  input  logic                   out_rdy_i,
  output butres_t                res_x_o,
  output butres_t                res_y_o,
  output logic [P_TAG_W-1:0]     tag_o,
  output logic                   ovf_o,
  output logic [P_OVF_CNT_W-1:0] ovf_cnt_o,
  input  logic                   ovf_clr_i
);

  localparam logic [P_OVF_CNT_W-1:0] CNT_ONE = {{(P_OVF_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [P_OVF_CNT_W-1:0] CNT_MAX = {P_OVF_CNT_W{1'b1}};

  // Sign-extend a 42-bit product into the 44-bit accumulation width.
  function automatic logic signed [43:0] ext44(input logic signed [41:0] v);
    return {{2{v[41]}}, v};
  endfunction

  // A 44-bit value fits in signed 42 bits only when its top three bits agree.
  function automatic logic is_sat(input logic signed [43:0] v);
    return !((v[43:41] == 3'b000) || (v[43:41] == 3'b111));
  endfunction

  // Clamp a 44-bit value to the signed 42-bit range.
  function automatic logic signed [41:0] sat42(input logic signed [43:0] v);
    logic signed [41:0] r;
    if (!is_sat(v)) begin
      r = v[41:0];
    end else if (v[43]) begin
      r = {1'b1, 41'd0};
    end else begin
      r = {1'b0, {41{1'b1}}};
    end
    return r;
  endfunction

  logic en_s;

  logic signed [41:0] b_re_ext_s, b_im_ext_s, w_re_ext_s, w_im_ext_s;

  logic               s1_vld_r;
  logic signed [41:0] s1_p_rr_r, s1_p_ii_r, s1_p_ri_r, s1_p_ir_r;
  fft_sample_t        s1_a_r;
  logic [P_TAG_W-1:0] s1_tag_r;

  logic signed [43:0] wb_re_s, wb_im_s, a_re_sh_s, a_im_sh_s;

  logic               s2_vld_r;
  logic signed [43:0] s2_wb_re_r, s2_wb_im_r, s2_a_re_r, s2_a_im_r;
  logic [P_TAG_W-1:0] s2_tag_r;

  logic signed [43:0] sum_xre_s, sum_xim_s, sum_yre_s, sum_yim_s;
  butres_t            res_x_s, res_y_s;
  logic               sat_any_s;

  // The whole pipeline advances only when the output slot is free or draining.
  assign en_s     = !out_vld_o || out_rdy_i;
  assign in_rdy_o = en_s;

  // Widen multiplier operands so the products are formed at full 42-bit width.
  always_comb begin
    b_re_ext_s = {{10{sample_b_i.re[31]}}, sample_b_i.re};
    b_im_ext_s = {{10{sample_b_i.im[31]}}, sample_b_i.im};
    w_re_ext_s = {{32{twdl_i.re[9]}}, twdl_i.re};
    w_im_ext_s = {{32{twdl_i.im[9]}}, twdl_i.im};
  end

  // Stage 1: register the four partial products, operand A and the tag.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      s1_vld_r  <= 1'b0;
      s1_p_rr_r <= 42'sd0;
      s1_p_ii_r <= 42'sd0;
      s1_p_ri_r <= 42'sd0;
      s1_p_ir_r <= 42'sd0;
      s1_a_r    <= '0;
      s1_tag_r  <= '0;
    end else if (en_s) begin
      s1_vld_r  <= in_vld_i;
      s1_p_rr_r <= b_re_ext_s * w_re_ext_s;
      s1_p_ii_r <= b_im_ext_s * w_im_ext_s;
      s1_p_ri_r <= b_re_ext_s * w_im_ext_s;
      s1_p_ir_r <= b_im_ext_s * w_re_ext_s;
      s1_a_r    <= sample_a_i;
      s1_tag_r  <= tag_i;
    end
  end

  // Combine partial products into W*B and align A to the 2^9 twiddle scale.
  always_comb begin
    wb_re_s   = ext44(s1_p_rr_r) - ext44(s1_p_ii_r);
    wb_im_s   = ext44(s1_p_ri_r) + ext44(s1_p_ir_r);
    a_re_sh_s = {{3{s1_a_r.re[31]}}, s1_a_r.re, 9'd0};
    a_im_sh_s = {{3{s1_a_r.im[31]}}, s1_a_r.im, 9'd0};
  end

  // Stage 2: register W*B and the scaled A.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      s2_vld_r   <= 1'b0;
      s2_wb_re_r <= 44'sd0;
      s2_wb_im_r <= 44'sd0;
      s2_a_re_r  <= 44'sd0;
      s2_a_im_r  <= 44'sd0;
      s2_tag_r   <= '0;
    end else if (en_s) begin
      s2_vld_r   <= s1_vld_r;
      s2_wb_re_r <= wb_re_s;
      s2_wb_im_r <= wb_im_s;
      s2_a_re_r  <= a_re_sh_s;
      s2_a_im_r  <= a_im_sh_s;
      s2_tag_r   <= s1_tag_r;
    end
  end

  // Butterfly sums/differences, clamped to 42 bits, with a per-operation flag.
  always_comb begin
    sum_xre_s  = s2_a_re_r + s2_wb_re_r;
    sum_xim_s  = s2_a_im_r + s2_wb_im_r;
    sum_yre_s  = s2_a_re_r - s2_wb_re_r;
    sum_yim_s  = s2_a_im_r - s2_wb_im_r;
    res_x_s.re = sat42(sum_xre_s);
    res_x_s.im = sat42(sum_xim_s);
    res_y_s.re = sat42(sum_yre_s);
    res_y_s.im = sat42(sum_yim_s);
    sat_any_s  = is_sat(sum_xre_s) || is_sat(sum_xim_s) ||
                 is_sat(sum_yre_s) || is_sat(sum_yim_s);
  end

  // Stage 3: output registers, held while downstream applies backpressure.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      out_vld_o <= 1'b0;
      res_x_o   <= '0;
      res_y_o   <= '0;
      tag_o     <= '0;
    end else if (en_s) begin
      out_vld_o <= s2_vld_r;
      res_x_o   <= res_x_s;
      res_y_o   <= res_y_s;
      tag_o     <= s2_tag_r;
    end
  end

  // Saturation statistics; a clear wins over a coincident saturation event.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      ovf_o     <= 1'b0;
      ovf_cnt_o <= '0;
    end else if (ovf_clr_i) begin
      ovf_o     <= 1'b0;
      ovf_cnt_o <= '0;
    end else if (en_s && s2_vld_r && sat_any_s) begin
      ovf_o <= 1'b1;
      if (ovf_cnt_o != CNT_MAX) begin
        ovf_cnt_o <= ovf_cnt_o + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/syn_fft_butterfly.md
# syn_fft_butterfly

Pipelined radix-2 decimation-in-time butterfly for the FFT datapath. It takes two complex samples A and B (fft_sample_t) and a twiddle W (fft_twdl_t). It produces X = A·2^9 + W·B and Y = A·2^9 − W·B as butres_t results for the downstream normalise/write-back stage. It has a valid/ready handshake with backpressure, passes an index tag through alongside the data, and keeps saturation statistics.

## Interface
- P_TAG_W, 8, width of the sideband tag carried alongside each operation.
- P_OVF_CNT_W, 16, width of the saturation event counter.
- clk_ir  in  1  system clock; all logic is on the rising edge.
- rst_ih  in  1  asynchronous, active-high reset.
- in_vld_i  in  1  input operation valid.
- in_rdy_o  out  1  butterfly can accept an operation this cycle.
- sample_a_i  in  fft_sample_t  operand A (signed re/im, 32b each).
- sample_b_i  in  fft_sample_t  operand B (signed re/im, 32b each).
- twdl_i  in  fft_twdl_t  twiddle W (signed Q1.9 re/im, 10b each).
- tag_i  in  P_TAG_W  sideband tag, e.g. sample index.
- out_vld_o  out  1  result valid.
- out_rdy_i  in  1  downstream accepts the result.
- res_x_o  out  butres_t  X = A·2^9 + W·B (signed 42b re/im).
- res_y_o  out  butres_t  Y = A·2^9 − W·B (signed 42b re/im).
- tag_o  out  P_TAG_W  tag of the operation currently on the outputs.
- ovf_o  out  1  sticky flag: some output component has saturated.
- ovf_cnt_o  out  P_OVF_CNT_W  count of saturated operations; saturates at all-ones.
- ovf_clr_i  in  1  synchronous clear of ovf_o and ovf_cnt_o.

## Operation
- Three-stage pipeline. Each stage holds a valid bit, its data and the tag.
  - S1: registers the four signed 32×10 products Bre·Wre, Bim·Wim, Bre·Wim, Bim·Wre (42b each). Also registers A and the tag.
  - S2: computes WBre = Bre·Wre − Bim·Wim and WBim = Bre·Wim + Bim·Wre at 44b. Registers these together with A sign-extended and shifted left by 9 (44b).
  - S3: computes four 44b sums/differences. Each is saturated to signed 42b: max 2^41−1, min −2^41. The results are registered as res_x_o and res_y_o.
- Stall: en = !out_vld_o || out_rdy_i. When en=0, every stage holds. in_rdy_o = en.
- An operation is accepted when in_vld_i && in_rdy_o. Valid bits shift one stage on every enabled cycle.
- Bubbles are not collapsed. An empty stage still takes one enabled cycle to pass through.
- Saturation accounting happens at S3 load, when en=1 and S2 is valid.
  - If any of the 4 components saturates, set ovf_o and increment ovf_cnt_o by 1. This is one count per operation, not per component.
  - The counter holds at 2^P_OVF_CNT_W − 1.
- ovf_clr_i has priority over a same-cycle saturation event. Both are cleared, and that event is lost.
- Rounding: none. The 2^9 scaling is kept in the output and removed by the downstream stage.

## Timing
- Latency: 3 cycles from acceptance to out_vld_o, with no backpressure.
- Throughput: 1 operation per cycle while out_rdy_i=1.
- While out_vld_o=1 and out_rdy_i=0:
  - res_x_o, res_y_o and tag_o are held stable.
  - in_rdy_o=0 and inputs are ignored.
- in_rdy_o is combinational from out_rdy_i and out_vld_o. No other combinational input-to-output path exists.
- Reset values: every valid bit 0, out_vld_o=0, res_x_o=0, res_y_o=0, tag_o=0, ovf_o=0, ovf_cnt_o=0. in_rdy_o=1 one gate delay after reset asserts.
- Reset mid-operation: all in-flight operations are discarded and no output is produced for them.
- The datapath registers are allowed to load while their stage is invalid, as long as en=1.

## Test plan
- Basic: A=(100,0), B=(10,0), W=(256,0) -> 3 cycles later X=(53760,0), Y=(48640,0), tag echoed, ovf_o=0.
- Complex: A=(0,0), B=(3,5), W=(256,−256) -> X=(2048,512), Y=(−2048,−512).
- Saturation: A=(2^31−1,0), B=(2^31−1,−2^31), W=(511,511):
  - X=(2^41−1, −511) and Y=(−1095216660481, 511).
  - ovf_o=1 and ovf_cnt_o=1.
- Backpressure: stream 8 tagged operations (tags 0–7), holding out_rdy_i=0 for cycles 5–9.
  - Outputs stay stable while stalled.
  - All 8 results emerge in order with no loss or duplication.
  - in_rdy_o=0 throughout the stall.
- Clear and counter: 3 saturating operations -> ovf_cnt_o=3. Then ovf_clr_i in the same cycle as a 4th saturating S3 load -> ovf_cnt_o=0, ovf_o=0.
- Reset: assert rst_ih with 2 operations in flight -> out_vld_o=0 immediately and all outputs zero. No stale result appears after release.
